// File: rtl/bus_arbiter_pkg.sv
// Shared bus types for the external memory bus arbiter:
// cycle widths, arbiter states and the request legality check.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        CW_BYTE = 2'd0,
        CW_WORD = 2'd1,
        CW_LONG = 2'd2
    } t_cycle_width;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } t_arb_state;

    // Width 3 is reserved; exactly one of read/write may be set.
    function automatic logic req_valid(
        input t_cycle_width w,
        input logic [1:0]   a,
        input logic         rd,
        input logic         wr
    );
        logic aligned;
        aligned = 1'b0;
        unique case (w)
            CW_BYTE: aligned = 1'b1;
            CW_WORD: aligned = ~a[0];
            CW_LONG: aligned = (a == 2'b00);
            default: aligned = 1'b0;
        endcase
        return aligned && (rd ^ wr);
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Shares the external memory bus between instruction fetch and the
// memory stage: data-first priority with a fetch fairness cap.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         fetch_req,
    input  logic [31:0]  fetch_address,
    output logic         fetch_ack,
    output logic [31:0]  fetch_data,
    output logic         fetch_error,
    input  logic         data_req,
    input  logic         data_read,
    input  logic         data_write,
    input  t_cycle_width data_width,
    input  logic [31:0]  data_address,
    input  logic [31:0]  data_wdata,
    output logic         data_ack,
    output logic [31:0]  data_rdata,
    output logic         data_error,
    output logic         fetch_blocked,
    output logic [31:0]  bus_address,
    output t_cycle_width bus_cycle_width,
    output logic         bus_read,
    output logic         bus_write,
    output logic [31:0]  bus_wdata,
    input  logic [31:0]  bus_rdata,
    input  logic         bus_ready
);

    localparam logic [3:0] STREAK_CAP = 4'(MAX_DATA_STREAK);
    localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT_CYCLES);

    t_arb_state   state_q, state_d;
    logic [3:0]   streak_q, streak_d;
    logic [7:0]   tmo_q, tmo_d;
    logic         fetch_ack_q, fetch_ack_d;
    logic         fetch_err_q, fetch_err_d;
    logic [31:0]  fetch_data_q, fetch_data_d;
    logic         data_ack_q, data_ack_d;
    logic         data_err_q, data_err_d;
    logic [31:0]  data_rdata_q, data_rdata_d;
    logic         blocked_q, blocked_d;
    logic [31:0]  bus_addr_q, bus_addr_d;
    t_cycle_width bus_width_q, bus_width_d;
    logic         bus_read_q, bus_read_d;
    logic         bus_write_q, bus_write_d;
    logic [31:0]  bus_wdata_q, bus_wdata_d;

    logic [7:0]   tmo_inc;
    logic         data_wins;
    logic         unused_fetch_lsb;

    assign tmo_inc          = tmo_q + 8'd1;
    assign data_wins        = data_req
                            && (streak_q < STREAK_CAP || !fetch_req);
    assign unused_fetch_lsb = ^fetch_address[1:0];

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        tmo_d        = tmo_q;
        fetch_ack_d  = 1'b0;
        fetch_err_d  = 1'b0;
        fetch_data_d = fetch_data_q;
        data_ack_d   = 1'b0;
        data_err_d   = 1'b0;
        data_rdata_d = data_rdata_q;
        blocked_d    = blocked_q;
        bus_addr_d   = bus_addr_q;
        bus_width_d  = bus_width_q;
        bus_read_d   = bus_read_q;
        bus_write_d  = bus_write_q;
        bus_wdata_d  = bus_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (data_wins) begin
                    streak_d = fetch_req ? streak_q + 4'd1 : 4'd0;
                    if (req_valid(data_width, data_address[1:0],
                                  data_read, data_write)) begin
                        state_d     = DATA;
                        bus_addr_d  = data_address;
                        bus_width_d = data_width;
                        bus_wdata_d = data_wdata;
                        bus_read_d  = data_read;
                        bus_write_d = data_write;
                        blocked_d   = 1'b1;
                    end else begin
                        state_d    = DONE;
                        data_ack_d = 1'b1;
                        data_err_d = 1'b1;
                    end
                end else if (fetch_req) begin
                    streak_d    = 4'd0;
                    state_d     = FETCH;
                    bus_addr_d  = {fetch_address[31:2], 2'b00};
                    bus_width_d = CW_LONG;
                    bus_read_d  = 1'b1;
                    bus_write_d = 1'b0;
                end else begin
                    streak_d = 4'd0;
                end
            end
            FETCH: begin
                if (bus_ready || tmo_inc == TMO_LIMIT) begin
                    state_d     = DONE;
                    tmo_d       = 8'd0;
                    bus_read_d  = 1'b0;
                    fetch_ack_d = 1'b1;
                    if (bus_ready) fetch_data_d = bus_rdata;
                    else           fetch_err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            DATA: begin
                if (bus_ready || tmo_inc == TMO_LIMIT) begin
                    state_d     = DONE;
                    tmo_d       = 8'd0;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    blocked_d   = 1'b0;
                    data_ack_d  = 1'b1;
                    if (!bus_ready)     data_err_d   = 1'b1;
                    else if (bus_read_q) data_rdata_d = bus_rdata;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            streak_q     <= 4'd0;
            tmo_q        <= 8'd0;
            fetch_ack_q  <= 1'b0;
            fetch_err_q  <= 1'b0;
            fetch_data_q <= 32'd0;
            data_ack_q   <= 1'b0;
            data_err_q   <= 1'b0;
            data_rdata_q <= 32'd0;
            blocked_q    <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_width_q  <= CW_LONG;
            bus_read_q   <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            tmo_q        <= tmo_d;
            fetch_ack_q  <= fetch_ack_d;
            fetch_err_q  <= fetch_err_d;
            fetch_data_q <= fetch_data_d;
            data_ack_q   <= data_ack_d;
            data_err_q   <= data_err_d;
            data_rdata_q <= data_rdata_d;
            blocked_q    <= blocked_d;
            bus_addr_q   <= bus_addr_d;
            bus_width_q  <= bus_width_d;
            bus_read_q   <= bus_read_d;
            bus_write_q  <= bus_write_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign fetch_ack       = fetch_ack_q;
    assign fetch_error     = fetch_err_q;
    assign fetch_data      = fetch_data_q;
    assign data_ack        = data_ack_q;
    assign data_error      = data_err_q;
    assign data_rdata      = data_rdata_q;
    assign fetch_blocked   = blocked_q;
    assign bus_address     = bus_addr_q;
    assign bus_cycle_width = bus_width_q;
    assign bus_read        = bus_read_q;
    assign bus_write       = bus_write_q;
    assign bus_wdata       = bus_wdata_q;

endmodule
